pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the five-stage RV32I core. It drives the enable and flush inputs of pipeline registers q1q2, q2q3, q3q4, q4q5 and q5q6, plus the PC enable. Sources are load-use hazards, taken branches/jumps, data-memory wait states and an EBREAK halt. It sits beside the datapath and owns no data. It only decides which stage registers capture and which ones load a bubble (NOP 32'h00000013, control 0).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int Q1Q2 = 0;
    localparam int Q2Q3 = 1;
    localparam int Q3Q4 = 2;
    localparam int Q4Q5 = 3;
    localparam int Q5Q6 = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use comparator between EX and ID
module pipe_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (ex_rd == id_rs1);
    assign rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
    // x0 is never written, so a load targeting it cannot create a hazard
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage core; optional PIPE_HAZARD_CTRL_PERF_EN counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       dmem_ready,
    input  logic       wb_halt,
    input  logic       resume,
    output logic       pc_en,
    output logic [4:0] stage_en,
    output logic [4:0] stage_flush,
    output logic       halted,
    output logic       mem_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_halt_cycles
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          load_use;
    logic          wait_active;
    logic          redirect_taken;

    pipe_hazard_detect u_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign wait_active = mem_req && !dmem_ready && (state != HALT);
    assign halted      = (state == HALT);

    always_comb begin
        state_nxt      = state;
        pc_en          = 1'b1;
        stage_en       = 5'b11111;
        stage_flush    = 5'b00000;
        redirect_taken = 1'b0;
        wait_cnt_nxt   = '0;
        if (!rst_n) begin
            // every pipeline register loads a bubble while reset is held
            pc_en       = 1'b0;
            stage_flush = 5'b11111;
        end else if (state == HALT) begin
            pc_en    = 1'b0;
            stage_en = 5'b00000;
            if (resume) begin
                stage_en[Q5Q6]    = 1'b1;
                stage_flush[Q5Q6] = 1'b1;
                state_nxt         = RUN;
            end
        end else if (wait_active) begin
            pc_en             = 1'b0;
            stage_en          = 5'b00000;
            stage_en[Q5Q6]    = 1'b1;
            stage_flush[Q5Q6] = 1'b1;
            state_nxt         = MEM_WAIT;
            wait_cnt_nxt      = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
        end else if (wb_halt) begin
            pc_en     = 1'b0;
            stage_en  = 5'b00000;
            state_nxt = HALT;
        end else begin
            state_nxt = RUN;
            if (ex_redirect) begin
                redirect_taken    = 1'b1;
                stage_flush[Q1Q2] = 1'b1;
                stage_flush[Q2Q3] = 1'b1;
            end else if (load_use) begin
                pc_en             = 1'b0;
                stage_en[Q1Q2]    = 1'b0;
                stage_flush[Q2Q3] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (wait_active && (wait_cnt_nxt == CNT_MAX)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
            perf_halt_cycles  <= '0;
        end else begin
            if (!pc_en && (state != HALT)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect_taken) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
            if (state == HALT) begin
                perf_halt_cycles <= perf_halt_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
